// File: rtl/div_arbiter_pkg.sv
// Shared constants and types for the divider arbiter.
// Provides the divider handshake encodings (start/stop, result-ready, reset level,
// zero word) and the arbiter state encoding used by div_arbiter.
package div_arbiter_pkg;

    localparam logic        DivStart       = 1'b1;
    localparam logic        DivStop        = 1'b0;
    localparam logic        DivResultReady = 1'b1;
    localparam logic        RstEnable      = 1'b1;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbBusy    = 2'd1,
        ArbRelease = 2'd2,
        ArbAbort   = 2'd3
    } arb_state_e;

    // Abort holds annul for two cycles: cnt counts 0 then 1.
    localparam logic [1:0] AbortLast = 2'd1;

endpackage

// File: rtl/div_rr_pick.sv
// Two-way round-robin picker.
// Ports:
//   valid   in  2  eligible requesters
//   pointer in  1  preferred port this round
//   grant   out 2  one-hot grant (or zero when nothing is eligible)
module div_rr_pick (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (pointer) begin
            if (valid[1])      grant = 2'b10;
            else if (valid[0]) grant = 2'b01;
        end else begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative 32-bit divider between two requesters
// (port 0: EX-stage div/divu, port 1: coprocessor/auxiliary path).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/signed/op1/op2      request from port N, held until accepted
//   reqN_flush                     owner cancels its in-flight divide
//   reqN_ready                     combinational accept for port N
//   respN_valid/result             one-cycle result pulse, result held until next response
//   div_start_o/annul_o/signed_o   divider control
//   div_op1_o/div_op2_o            divider operands, stable for the whole divide
//   div_result_i/div_ready_i       divider result and ready
module div_arbiter
    import div_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_signed,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req0_flush,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_signed,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic        req1_flush,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [63:0] resp0_result,
    output logic        resp1_valid,
    output logic [63:0] resp1_result,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    arb_state_e  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        annul_q, annul_d;
    logic        sgn_q, sgn_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic        rv0_q, rv0_d;
    logic        rv1_q, rv1_d;
    logic [63:0] rr0_q, rr0_d;
    logic [63:0] rr1_q, rr1_d;

    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic        owner_flush;

    // A port flushing in the same cycle must not start a new divide.
    assign eligible    = {req1_valid & ~req1_flush, req0_valid & ~req0_flush};
    assign owner_flush = owner_q ? req1_flush : req0_flush;

    div_rr_pick u_pick (
        .valid   (eligible),
        .pointer (ptr_q),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        annul_d    = annul_q;
        sgn_d      = sgn_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rv0_d      = 1'b0;
        rv1_d      = 1'b0;
        rr0_d      = rr0_q;
        rr1_d      = rr1_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            ArbIdle: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (|grant) begin
                    owner_d = grant[1];
                    ptr_d   = ~grant[1];
                    sgn_d   = grant[1] ? req1_signed : req0_signed;
                    op1_d   = grant[1] ? req1_op1    : req0_op1;
                    op2_d   = grant[1] ? req1_op2    : req0_op2;
                    start_d = DivStart;
                    state_d = ArbBusy;
                end
            end
            ArbBusy: begin
                // Flush wins over a coincident ready; the result is dropped.
                if (owner_flush) begin
                    start_d = DivStop;
                    annul_d = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = ArbAbort;
                end else if (div_ready_i == DivResultReady) begin
                    start_d = DivStop;
                    state_d = ArbRelease;
                    if (owner_q) begin
                        rv1_d = 1'b1;
                        rr1_d = div_result_i;
                    end else begin
                        rv0_d = 1'b1;
                        rr0_d = div_result_i;
                    end
                end
            end
            ArbRelease: begin
                // One cycle of start low lets the divider drop out of its end state.
                state_d = ArbIdle;
            end
            ArbAbort: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == AbortLast) begin
                    annul_d = 1'b0;
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ArbIdle;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 2'd0;
            start_q <= DivStop;
            annul_q <= 1'b0;
            sgn_q   <= 1'b0;
            op1_q   <= ZeroWord;
            op2_q   <= ZeroWord;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rr0_q   <= {ZeroWord, ZeroWord};
            rr1_q   <= {ZeroWord, ZeroWord};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            annul_q <= annul_d;
            sgn_q   <= sgn_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rr0_q   <= rr0_d;
            rr1_q   <= rr1_d;
        end
    end

    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = sgn_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign resp0_valid  = rv0_q;
    assign resp1_valid  = rv1_q;
    assign resp0_result = rr0_q;
    assign resp1_result = rr1_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: behavioural iterative divider model plus a scoreboard.
// Drivers push the hand-computed expected response (port, result, cycle) on accept;
// a monitor pops and compares whenever a response pulse appears.
module tb_div_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_signed, req0_flush, req0_ready;
    logic [31:0] req0_op1, req0_op2;
    logic        req1_valid, req1_signed, req1_flush, req1_ready;
    logic [31:0] req1_op1, req1_op2;
    logic        resp0_valid, resp1_valid;
    logic [63:0] resp0_result, resp1_result;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    div_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_signed  (req0_signed),
        .req0_op1     (req0_op1),
        .req0_op2     (req0_op2),
        .req0_flush   (req0_flush),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_signed  (req1_signed),
        .req1_op1     (req1_op1),
        .req1_op2     (req1_op2),
        .req1_flush   (req1_flush),
        .req1_ready   (req1_ready),
        .resp0_valid  (resp0_valid),
        .resp0_result (resp0_result),
        .resp1_valid  (resp1_valid),
        .resp1_result (resp1_result),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Divider model: Free -> On (33 cycles) or ByZero -> End, ready registered in End.
    typedef enum logic [1:0] {MFree, MOn, MZero, MEnd} mdiv_e;
    mdiv_e       m_state;
    int          m_cnt;
    logic [63:0] m_res;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state      <= MFree;
            m_cnt        <= 0;
            m_res        <= 64'h0;
            div_ready_i  <= 1'b0;
            div_result_i <= 64'h0;
        end else begin
            case (m_state)
                MFree: begin
                    div_ready_i  <= 1'b0;
                    div_result_i <= 64'h0;
                    if (div_start_o && !div_annul_o) begin
                        if (div_op2_o == 32'h0) m_state <= MZero;
                        else begin
                            m_state <= MOn;
                            m_cnt   <= 0;
                        end
                    end
                end
                MZero: begin
                    m_res   <= 64'h0;
                    m_state <= MEnd;
                end
                MOn: begin
                    if (div_annul_o) m_state <= MFree;
                    else if (m_cnt != 32) m_cnt <= m_cnt + 1;
                    else begin
                        // Operands re-read here, so unstable operands corrupt the result.
                        m_res   <= ref_div(div_signed_o, div_op1_o, div_op2_o);
                        m_state <= MEnd;
                    end
                end
                default: begin
                    if (!div_start_o) begin
                        m_state      <= MFree;
                        div_ready_i  <= 1'b0;
                        div_result_i <= 64'h0;
                    end else begin
                        div_ready_i  <= 1'b1;
                        div_result_i <= m_res;
                    end
                end
            endcase
        end
    end

    typedef struct {
        int          port;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_port[$];
    int          grant_cyc[$];
    logic        exp_sgn = 1'b0;
    logic [31:0] exp_op1 = 32'h0;
    logic [31:0] exp_op2 = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (resp0_valid || resp1_valid) begin
                if (resp0_valid && resp1_valid) check("resp_both_ports", 64'd1, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp at cycle %0d: got resp0=%0b resp1=%0b expected none",
                             cyc, resp0_valid, resp1_valid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_port", 64'(resp1_valid), 64'(e.port));
                    check("resp_result", resp1_valid ? resp1_result : resp0_result, e.res);
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (div_start_o) begin
                check("op1_stable", 64'(div_op1_o), 64'(exp_op1));
                check("op2_stable", 64'(div_op2_o), 64'(exp_op2));
                check("signed_stable", 64'(div_signed_o), 64'(exp_sgn));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0; req0_flush = 1'b0; req1_valid = 1'b0; req1_flush = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents a request, waits (bounded) for accept, logs the expected response.
    task automatic do_req(input int port, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int lat,
                          input logic exp_resp, output int t_acc);
        logic got;
        int   n;
        got   = 1'b0;
        n     = 0;
        t_acc = -1;
        if (port == 0) begin
            req0_valid = 1'b1; req0_signed = sgn; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = 1'b1; req1_signed = sgn; req1_op1 = a; req1_op2 = b;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = (port == 0) ? req0_ready : req1_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout port %0d: got no ready expected ready within 200", port);
        end else begin
            t_acc = cyc;
            if (port == 0 && req1_valid) check("other_ready0", 64'(req1_ready), 64'd0);
            if (port == 1 && req0_valid) check("other_ready1", 64'(req0_ready), 64'd0);
            exp_sgn = sgn;
            exp_op1 = a;
            exp_op2 = b;
            grant_port.push_back(port);
            grant_cyc.push_back(cyc);
            if (exp_resp) sb.push_back('{port: port, res: exp_res, cyc: cyc + lat});
        end
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        rst = 1'b1;
        req0_valid = 1'b0; req0_signed = 1'b0; req0_op1 = 32'h0; req0_op2 = 32'h0;
        req1_valid = 1'b0; req1_signed = 1'b0; req1_op1 = 32'h0; req1_op2 = 32'h0;
        req0_flush = 1'b0; req1_flush = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_start", 64'(div_start_o), 64'd0);
        check("rst_annul", 64'(div_annul_o), 64'd0);
        check("rst_op1", 64'(div_op1_o), 64'd0);
        check("rst_resp0", resp0_result, 64'd0);
        check("rst_resp1", resp1_result, 64'd0);
        // A port flushing in IDLE is not eligible; the other port takes the grant
        req0_valid = 1'b1; req0_flush = 1'b1; req1_valid = 1'b1;
        #1;
        check("idle_flush_ready0", 64'(req0_ready), 64'd0);
        check("idle_flush_ready1", 64'(req1_ready), 64'd1);
        req0_valid = 1'b0; req0_flush = 1'b0; req1_valid = 1'b0;

        // Port 0 alone, unsigned 100/7
        do_reset();
        do_req(0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 37, 1'b1, t0);
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            check("start_window", 64'(div_start_o), (k <= 36) ? 64'd1 : 64'd0);
        end

        // Port 1 signed -7/2, non-owner flush mid-divide is ignored
        do_reset();
        do_req(1, 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 37, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1;
        req0_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req0_flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Both valid continuously: grants alternate 0,1,0,1 38 cycles apart
        do_reset();
        grant_port.delete();
        grant_cyc.delete();
        fork
            begin
                do_req(0, 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 37, 1'b1, t0);
                do_req(0, 1'b1, 32'd20, 32'hFFFF_FFFD, 64'h00000002_FFFFFFFA, 37, 1'b1, t0);
            end
            begin
                do_req(1, 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 37, 1'b1, t1);
                do_req(1, 1'b0, 32'd7, 32'd9, 64'h00000007_00000000, 37, 1'b1, t1);
            end
        join
        check("grant_count", 64'(grant_port.size()), 64'd4);
        for (int i = 0; i < grant_port.size(); i++) begin
            check("grant_order", 64'(grant_port[i]), 64'(i % 2));
            if (i > 0) check("grant_gap", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd38);
        end
        repeat (40) @(posedge clk);
        #1;

        // Divide by zero on port 0, port 1 pending
        do_reset();
        fork
            do_req(0, 1'b0, 32'd5, 32'd0, 64'h0, 5, 1'b1, t0);
            do_req(1, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 37, 1'b1, t1);
        join
        check("dbz_next_accept", 64'(t1 - t0), 64'd6);
        repeat (40) @(posedge clk);
        #1;

        // Owner flush at t+10, port 1 pending
        do_reset();
        fork
            begin
                do_req(0, 1'b0, 32'd100, 32'd7, 64'h0, 37, 1'b0, t0);
                repeat (9) @(posedge clk);
                #1;
                req0_flush = 1'b1;
                @(negedge clk);
                check("annul_before", 64'(div_annul_o), 64'd0);
                @(posedge clk);
                #1;
                req0_flush = 1'b0;
                @(negedge clk);
                check("annul_f1", 64'(div_annul_o), 64'd1);
                check("start_f1", 64'(div_start_o), 64'd0);
                @(negedge clk);
                check("annul_f2", 64'(div_annul_o), 64'd1);
                @(negedge clk);
                check("annul_f3", 64'(div_annul_o), 64'd0);
            end
            do_req(1, 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 37, 1'b1, t1);
        join
        check("flush_next_accept", 64'(t1 - t0), 64'd13);
        repeat (40) @(posedge clk);
        #1;

        // Flush coincident with div_ready_i
        do_reset();
        do_req(0, 1'b0, 32'd100, 32'd7, 64'h0, 37, 1'b0, t0);
        repeat (35) @(posedge clk);
        #1;
        req0_flush = 1'b1;
        @(negedge clk);
        check("coinc_ready_seen", 64'(div_ready_i), 64'd1);
        @(posedge clk);
        #1;
        req0_flush = 1'b0;
        @(negedge clk);
        check("coinc_annul", 64'(div_annul_o), 64'd1);
        repeat (5) @(posedge clk);
        #1;

        // Reset mid-BUSY on port 1 (fallback grant with pointer at 0)
        do_reset();
        do_req(1, 1'b1, 32'h1234_5678, 32'd3, 64'h0, 37, 1'b0, t0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_start", 64'(div_start_o), 64'd0);
        check("mid_rst_annul", 64'(div_annul_o), 64'd0);
        check("mid_rst_signed", 64'(div_signed_o), 64'd0);
        check("mid_rst_op1", 64'(div_op1_o), 64'd0);
        check("mid_rst_op2", 64'(div_op2_o), 64'd0);
        check("mid_rst_resp1_res", resp1_result, 64'd0);
        check("mid_rst_resp0_res", resp0_result, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares the single iterative 32-bit divider between two requesters: port 0 is the EX-stage div/divu path and port 1 is the coprocessor/auxiliary path. It arbitrates round-robin and drives the divider's start/annul/operand inputs. It holds operands stable for the whole divide, captures the 64-bit result and returns it to the owning port. It also forwards pipeline flushes as annuls and guarantees the divider is back in its free state before the next grant.

## Interface
- No parameters; data width fixed at 32 (result 64).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  (N=0,1) request pending; held until accepted
- reqN_signed  in  1  signed divide when 1
- reqN_op1 / reqN_op2  in  32  dividend / divisor
- reqN_flush  in  1  owner cancels in-flight divide
- reqN_ready  out  1  combinational accept; transfer when valid&ready
- respN_valid  out  1  one-cycle result pulse
- respN_result  out  64  {remainder[63:32], quotient[31:0]}
- div_start_o  out  1  to divider start_i (DivStart/DivStop)
- div_annul_o  out  1  to divider annul_i
- div_signed_o  out  1  to divider signed_div_i
- div_op1_o / div_op2_o  out  32  to divider operands
- div_result_i  in  64  divider result
- div_ready_i  in  1  divider result ready

## Operation
- States: IDLE, BUSY, RELEASE, ABORT (2-bit cnt).
- IDLE: grant = pointer port if valid, else other port if valid. reqN_ready=1 only for the granted port; a port with flush=1 in the same cycle is not eligible. On accept:
  - latch signed/op1/op2 and owner;
  - flip pointer to the other port;
  - set div_start_o=1;
  - go to BUSY.
- BUSY: start=1 and latched operands are held constant. The divider re-reads operands during its final sign correction.
  - If owner flush=1: start=0, annul=1, cnt=0, go to ABORT. Flush has priority over a same-cycle div_ready_i, and the result is discarded.
  - Else if div_ready_i=1: register result into respN_result, pulse respN_valid next cycle, start=0, go to RELEASE.
- RELEASE: start=0 for one cycle so the divider leaves DivEnd. Then go to IDLE.
- ABORT: start=0, annul=1 for 2 cycles. This covers both DivOn (1 edge) and DivByZero→DivEnd→Free (2 edges). Then annul=0, go to IDLE. No resp pulse.
- Flush of the non-owner port is ignored.
- respN_result holds its last value until the next response on that port.
- Reset values: state IDLE, pointer=0, div_start_o=0, div_annul_o=0, div_signed_o=0, div_op*=0, respN_valid=0, respN_result=0.
- Reset mid-divide: the arbiter returns to IDLE and no response is issued. The divider shares rst.

## Timing
- Accept in cycle t. div_start_o=1 from t+1. Divider DivOn t+2..t+34, DivEnd t+35, div_ready_i seen t+36. respN_valid in t+37. RELEASE t+37. IDLE t+38, when the next accept is possible (period 38 cycles).
- Divide by zero: div_ready_i seen t+4, resp at t+5 with result 0. Next accept at t+6.
- Flush in BUSY at cycle f: annul t f+1..f+2. Next accept at f+3.
- All outputs except reqN_ready are registered.

## Structure
- Shared defines.v already provides DivStart/DivStop, DivResultReady, RstEnable and ZeroWord.
- Add the arbiter state encodings (ArbIdle, ArbBusy, ArbRelease, ArbAbort) to defines.v.
- One sub-module: div_rr_pick. It is a 2-way round-robin picker taking valid[1:0] and pointer, and returning grant[1:0].

## Test plan
- Port 0 alone, unsigned 100/7 → resp0_valid at t+37, result 0x00000002_0000000E. div_start_o stays high t+1..t+36 and is low at t+37.
- Port 1 signed -7/2 (0xFFFFFFF9/0x2) → result 0xFFFFFFFF_FFFFFFFD. Operand outputs are stable throughout.
- Both valid continuously → grants alternate 0,1,0,1 from reset, each 38 cycles apart. The unselected port sees ready=0.
- Divisor 0 on port 0 → resp0 at t+5, result 0. Port 1 is accepted at t+6.
- Owner flush at t+10 → annul high t+11..t+12, no resp. The pending other port is accepted at t+13, and its result is correct.
- Flush coincident with div_ready_i, and rst asserted mid-BUSY → no resp; all outputs reach reset values next cycle.
